ct_f_spsram_ctrl: RTL and testbench
===================================

Name: ct_f_spsram_ctrl

Overview:
Requester-side controller for the single-port FPGA SRAM macro interface (A/CEN/GWEN/WEN/D/Q, active-low enables, bit-wise write mask, synchronous read).
- Accepts read and write requests on a valid/ready port.
- Drives the SRAM pins, captures read data one cycle after the access, and returns it through a response FIFO with backpressure.
- After reset it optionally sweeps the whole array to a known value before accepting traffic.

Parameters:
ADDR_WIDTH, 10, SRAM address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 32, SRAM data width; multiple of 8
RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2
INIT_EN, 1, 1 = clear array after reset; 0 = skip init
INIT_VALUE, 0, DATA_WIDTH value written to every word during init

Ports:
CLK  in  1  clock; all logic on rising edge
RST_B  in  1  synchronous active-low reset
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_bmask  in  DATA_WIDTH/8  active-high byte enables for writes
rsp_vld  out  1  read response valid
rsp_rdy  in  1  read response ready
rsp_rdata  out  DATA_WIDTH  read data, oldest first
init_done  out  1  high once init finished; stays high until reset
sram_A  out  ADDR_WIDTH  to SRAM A
sram_CEN  out  1  to SRAM CEN, active low
sram_GWEN  out  1  to SRAM GWEN, active low
sram_WEN  out  DATA_WIDTH  to SRAM WEN, per-bit active low
sram_D  out  DATA_WIDTH  to SRAM D
sram_Q  in  DATA_WIDTH  from SRAM Q; valid the cycle after a CEN-low read

Behaviour:
- Reset: synchronous, RST_B=0 sampled at CLK. Applies in any state, including mid-init or with reads in flight; no completion of in-flight work.
  - Reset outputs: req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0.
  - Reset pin values: sram_CEN=1, sram_GWEN=1, sram_WEN=all 1, sram_A=0, sram_D=0.
  - Reset clears: FIFO flushed, rd_pend cleared, init counter cleared, FSM -> INIT (INIT_EN=1) or RUN (INIT_EN=0).
- States:
  - INIT: each cycle, write one word with sram_CEN=0, sram_GWEN=0, sram_WEN=all 0, sram_A=init_cnt, sram_D=INIT_VALUE. init_cnt counts 0..2^ADDR_WIDTH-1, so init takes exactly 2^ADDR_WIDTH cycles. After the write to the last address: -> RUN; init_done=1 next cycle. req_rdy=0 throughout INIT.
  - RUN: init_done=1. With INIT_EN=0, RUN and init_done=1 begin the first cycle after RST_B deasserts.
- Ready rule: req_rdy = (state==RUN) && (fifo_cnt + rd_pend < RSP_DEPTH).
  - Registered-state function only; req_rdy has no combinational dependence on req_vld, req_wr or rsp_rdy.
  - Applies to writes as well as reads.
- Request acceptance (req_vld && req_rdy): SRAM pins are driven combinationally in the same cycle. No other cycle has sram_CEN=0 in RUN.
  - Write: sram_CEN=0, sram_GWEN=0, sram_A=req_addr, sram_D=req_wdata, sram_WEN[8i+7:8i]=all 0 if req_bmask[i] else all 1. Produces no response. bmask=0 is a legal no-op write.
  - Read: sram_CEN=0, sram_GWEN=1, sram_WEN=all 1, sram_A=req_addr. rd_pend=1 in the next cycle.
- Idle RUN cycle: sram_CEN=1, sram_GWEN=1, sram_WEN=all 1, sram_A=0, sram_D=0.
- Capture: in a cycle with rd_pend=1, sram_Q is pushed into the FIFO. The ready rule guarantees space, so no overflow is possible. rd_pend clears unless another read was accepted in the previous cycle.
- Latency: read accepted in cycle N -> rsp_vld=1 with its data at cycle N+2 at the earliest (N+1 capture, N+2 registered FIFO head).
- Response FIFO:
  - rsp_vld = (fifo_cnt != 0); rsp_rdata = head entry, 0 when empty.
  - Pop on rsp_vld && rsp_rdy. Push and pop in the same cycle leaves the count unchanged.
  - Strict in-order delivery. rsp_rdata must stay stable while rsp_vld=1 and rsp_rdy=0.
- Throughput: RSP_DEPTH>=3 with rsp_rdy held 1 sustains one read per cycle.
- Read-after-write: a write in cycle N followed by a read of the same address in cycle N+1 returns the new data. Data is undefined until init completes or the first write when INIT_EN=0.

Test Plan:
1. Init sweep: RST_B low 2 cycles, then high -> sram_CEN low for exactly 1024 consecutive cycles, A=0..1023, D=0, WEN=all 0; init_done rises 1 cycle after A=1023; req_rdy=0 until then.
2. Masked write/readback: write addr 0x15 data 0xAABBCCDD bmask 4'b1111, then addr 0x15 data 0x11223344 bmask 4'b0101 -> sram_WEN=0xFF00FF00 on the second write; a read of 0x15 returns 0xAA22CC44 exactly 2 cycles after acceptance.
3. Backpressure: rsp_rdy=0, issue reads to 1,2,3,4,5 back-to-back -> 4 accepted, req_rdy=0 from then; rsp_rdata stays at word 1. Raise rsp_rdy -> data for 1,2,3,4 returned in order, req_rdy re-asserts, read 5 completes.
4. Streaming: rsp_rdy=1, 16 consecutive reads of addresses 0..15 -> req_rdy never drops; rsp_vld high for 16 consecutive cycles starting 2 cycles after the first accept.
5. Reset mid-operation: assert RST_B for 1 cycle at init_cnt=500, then separately with 3 responses queued and 1 read pending -> outputs return to reset values the next cycle; FIFO empty; init restarts at A=0; no stale response appears afterwards.
6. INIT_EN=0 build: release reset -> init_done=1 and req_rdy=1 on the first cycle after RST_B deasserts; sram_CEN stays 1 until the first request.

Source files
------------

// File: rtl/ct_f_spsram_ctrl.sv
// ct_f_spsram_ctrl: requester-side controller for a single-port synchronous SRAM
// macro with active-low enables and a per-bit write mask.
// Requests arrive on a valid/ready port. Read data is captured one cycle after
// the access and returned through a small response FIFO. After reset the array
// can optionally be swept to INIT_VALUE before any traffic is accepted.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high
// at the rising clock edge. Valid must not depend on ready. req_rdy depends only
// on registered state. rsp_rdata holds steady while rsp_vld is high and
// rsp_rdy is low.
module ct_f_spsram_ctrl #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RSP_DEPTH  = 4,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    CLK,
  input  logic                    RST_B,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_bmask,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_A,
  output logic                    sram_CEN,
  output logic                    sram_GWEN,
  output logic [DATA_WIDTH-1:0]   sram_WEN,
  output logic [DATA_WIDTH-1:0]   sram_D,
  input  logic [DATA_WIDTH-1:0]   sram_Q
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  // Low for the first cycle after reset so that no SRAM access happens while
  // RST_B is still held low.
  logic                    active_q;
  logic                    init_done_q;
  logic                    rd_pend_q;

  logic [DATA_WIDTH-1:0]   fifo_mem_q [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           fifo_cnt_q;

  logic                    init_wr;
  logic                    accept;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    push;
  logic                    pop;
  logic [CW-1:0]           occupancy;

  // Reserve one FIFO slot for every read still in the SRAM pipeline, so a
  // capture never finds the FIFO full.
  assign occupancy = fifo_cnt_q + CW'(rd_pend_q);
  // init_done_q is only ever set together with (or after) entering ST_RUN.
  assign req_rdy   = init_done_q && (occupancy < CW'(RSP_DEPTH));
  assign accept    = req_vld && req_rdy;
  assign rd_acc    = accept && !req_wr;
  assign wr_acc    = accept && req_wr;
  assign init_wr   = (state_q == ST_INIT) && active_q;
  assign push      = rd_pend_q;
  assign pop       = rsp_vld && rsp_rdy;

  assign init_done = init_done_q;
  assign rsp_vld   = (fifo_cnt_q != '0);
  assign rsp_rdata = rsp_vld ? fifo_mem_q[rd_ptr_q] : '0;

  // SRAM pin drive: init sweep, accepted write, accepted read, else idle.
  always_comb begin
    sram_CEN  = 1'b1;
    sram_GWEN = 1'b1;
    sram_WEN  = '1;
    sram_A    = '0;
    sram_D    = '0;
    if (init_wr) begin
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_WEN  = '0;
      sram_A    = init_cnt_q;
      sram_D    = INIT_VALUE;
    end else if (wr_acc) begin
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_A    = req_addr;
      sram_D    = req_wdata;
      for (int i = 0; i < BW; i++) begin
        sram_WEN[8*i +: 8] = {8{~req_bmask[i]}};
      end
    end else if (rd_acc) begin
      sram_CEN = 1'b0;
      sram_A   = req_addr;
    end
  end

  // Control FSM: init sweep counter, init_done flag and INIT -> RUN transition.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      active_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          if (active_q) begin
            init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == '1) begin
              state_q     <= ST_RUN;
              init_done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Read-pending flag: SRAM Q is valid the cycle after an accepted read.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_acc;
    end
  end

  // Response FIFO pointers and occupancy count.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Response FIFO storage: captured SRAM read data. Contents are masked by the
  // count, so the array needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= sram_Q;
    end
  end

endmodule

// File: tb/tb_ct_f_spsram_ctrl.sv
// Directed testbench for ct_f_spsram_ctrl with a behavioural SRAM model.
module tb_ct_f_spsram_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST_B;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- main DUT (INIT_EN=1) ----------------
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_bmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_A;
  logic          sram_CEN, sram_GWEN;
  logic [DW-1:0] sram_WEN, sram_D, sram_Q;

  ct_f_spsram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(4), .INIT_EN(1), .INIT_VALUE('0)
  ) u_dut (
    .CLK(CLK), .RST_B(RST_B),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_A(sram_A), .sram_CEN(sram_CEN), .sram_GWEN(sram_GWEN),
    .sram_WEN(sram_WEN), .sram_D(sram_D), .sram_Q(sram_Q)
  );

  // Behavioural single-port SRAM: per-bit active-low write mask, registered Q.
  logic [DW-1:0] mem [2**AW];
  always @(posedge CLK) begin
    if (!sram_CEN) begin
      if (!sram_GWEN) begin
        mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
      end else begin
        sram_Q <= mem[sram_A];
      end
    end
  end

  // ---------------- second DUT (INIT_EN=0), idle requester ----------------
  logic          n_req_rdy, n_rsp_vld, n_init_done, n_CEN, n_GWEN;
  logic [DW-1:0] n_rsp_rdata, n_WEN, n_D;
  logic [3:0]    n_A;
  logic          z_bit;
  logic [3:0]    z_addr;
  logic [DW-1:0] z_data;
  logic [BW-1:0] z_mask;
  assign z_bit  = 1'b0;
  assign z_addr = '0;
  assign z_data = '0;
  assign z_mask = '0;

  ct_f_spsram_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(DW), .RSP_DEPTH(2), .INIT_EN(0), .INIT_VALUE('0)
  ) u_dut_noinit (
    .CLK(CLK), .RST_B(RST_B),
    .req_vld(z_bit), .req_rdy(n_req_rdy), .req_wr(z_bit),
    .req_addr(z_addr), .req_wdata(z_data), .req_bmask(z_mask),
    .rsp_vld(n_rsp_vld), .rsp_rdy(z_bit), .rsp_rdata(n_rsp_rdata),
    .init_done(n_init_done),
    .sram_A(n_A), .sram_CEN(n_CEN), .sram_GWEN(n_GWEN),
    .sram_WEN(n_WEN), .sram_D(n_D), .sram_Q(z_data)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: wait for the rising edge, then move 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"},   64'(req_rdy),   64'd0);
    check({tag, "_rsp_vld"},   64'(rsp_vld),   64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_init_done"}, 64'(init_done), 64'd0);
    check({tag, "_CEN"},       64'(sram_CEN),  64'd1);
    check({tag, "_GWEN"},      64'(sram_GWEN), 64'd1);
    check({tag, "_WEN"},       64'(sram_WEN),  64'hFFFF_FFFF);
    check({tag, "_A"},         64'(sram_A),    64'd0);
    check({tag, "_D"},         64'(sram_D),    64'd0);
  endtask

  // Present one write for a cycle; it must be accepted immediately.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] m);
    logic [DW-1:0] exp_wen;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_bmask = m;
    for (int i = 0; i < BW; i++) exp_wen[8*i +: 8] = m[i] ? 8'h00 : 8'hFF;
    #1;
    check($sformatf("wr%0h_rdy", a),  64'(req_rdy),   64'd1);
    check($sformatf("wr%0h_CEN", a),  64'(sram_CEN),  64'd0);
    check($sformatf("wr%0h_GWEN", a), 64'(sram_GWEN), 64'd0);
    check($sformatf("wr%0h_A", a),    64'(sram_A),    64'(a));
    check($sformatf("wr%0h_D", a),    64'(sram_D),    64'(d));
    check($sformatf("wr%0h_WEN", a),  64'(sram_WEN),  64'(exp_wen));
    tick();
  endtask

  // Present one read for a cycle; it must be accepted immediately.
  task automatic do_read(input logic [AW-1:0] a);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = '0; req_bmask = '0;
    #1;
    check($sformatf("rd%0h_rdy", a),  64'(req_rdy),   64'd1);
    check($sformatf("rd%0h_CEN", a),  64'(sram_CEN),  64'd0);
    check($sformatf("rd%0h_GWEN", a), 64'(sram_GWEN), 64'd1);
    check($sformatf("rd%0h_WEN", a),  64'(sram_WEN),  64'hFFFF_FFFF);
    check($sformatf("rd%0h_A", a),    64'(sram_A),    64'(a));
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    RST_B = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_bmask = '0; rsp_rdy = 1'b1;

    // 1. Reset, then the init sweep.
    tick(); tick();
    check_reset_outputs("rst");
    check("noinit_rst_init_done", 64'(n_init_done), 64'd0);
    check("noinit_rst_req_rdy",   64'(n_req_rdy),   64'd0);
    check("noinit_rst_CEN",       64'(n_CEN),       64'd1);
    RST_B = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      check($sformatf("init_A_%0d", i),   64'(sram_A),   64'(i));
      check($sformatf("init_CEN_%0d", i), 64'(sram_CEN), 64'd0);
      check($sformatf("init_rdy_%0d", i), 64'(req_rdy),  64'd0);
      if (i == 0 || i == 1023) begin
        check($sformatf("init_GWEN_%0d", i), 64'(sram_GWEN), 64'd0);
        check($sformatf("init_WEN_%0d", i),  64'(sram_WEN),  64'd0);
        check($sformatf("init_D_%0d", i),    64'(sram_D),    64'd0);
        check($sformatf("init_done_%0d", i), 64'(init_done), 64'd0);
      end
      // 6. INIT_EN=0 instance: running from the first cycle after reset release.
      if (i == 0) begin
        check("noinit_init_done", 64'(n_init_done), 64'd1);
        check("noinit_req_rdy",   64'(n_req_rdy),   64'd1);
      end
      if (i < 6) check($sformatf("noinit_CEN_%0d", i), 64'(n_CEN), 64'd1);
    end
    tick();
    check("run_init_done", 64'(init_done), 64'd1);
    check("run_req_rdy",   64'(req_rdy),   64'd1);
    check("run_idle_CEN",  64'(sram_CEN),  64'd1);

    // 2. Masked write, then read-after-write with two-cycle latency.
    do_write(10'h15, 32'hAABB_CCDD, 4'b1111);
    do_write(10'h15, 32'h1122_3344, 4'b0101);
    do_read(10'h15);
    req_vld = 1'b0;
    #1;
    check("raw_n1_rsp_vld", 64'(rsp_vld),   64'd0);
    check("idle_CEN",       64'(sram_CEN),  64'd1);
    check("idle_GWEN",      64'(sram_GWEN), 64'd1);
    check("idle_WEN",       64'(sram_WEN),  64'hFFFF_FFFF);
    check("idle_A",         64'(sram_A),    64'd0);
    check("idle_D",         64'(sram_D),    64'd0);
    tick();
    check("raw_n2_rsp_vld",   64'(rsp_vld),   64'd1);
    check("raw_n2_rsp_rdata", 64'(rsp_rdata), 64'hAA22_CC44);
    tick();
    check("raw_n3_rsp_vld",   64'(rsp_vld),   64'd0);
    check("raw_n3_rsp_rdata", 64'(rsp_rdata), 64'd0);

    // 3. Backpressure: four reads fill the FIFO, the fifth waits.
    for (int a = 1; a <= 5; a++) do_write(AW'(a), 32'hA000_0000 | DW'(a), 4'hF);
    rsp_rdy = 1'b0;
    for (int a = 1; a <= 4; a++) do_read(AW'(a));
    req_addr = 10'd5;
    #1;
    check("bp_c4_rdy",   64'(req_rdy),   64'd0);
    check("bp_c4_vld",   64'(rsp_vld),   64'd1);
    check("bp_c4_rdata", 64'(rsp_rdata), 64'hA000_0001);
    tick();
    check("bp_c5_rdy",   64'(req_rdy),   64'd0);
    check("bp_c5_CEN",   64'(sram_CEN),  64'd1);
    check("bp_c5_rdata", 64'(rsp_rdata), 64'hA000_0001);
    tick();
    check("bp_c6_rdy",   64'(req_rdy),   64'd0);
    check("bp_c6_rdata", 64'(rsp_rdata), 64'hA000_0001);
    rsp_rdy = 1'b1;
    #1;
    check("bp_x0_rdy",   64'(req_rdy),   64'd0);
    check("bp_x0_rdata", 64'(rsp_rdata), 64'hA000_0001);
    tick();
    check("bp_x1_rdy",   64'(req_rdy),   64'd1);
    check("bp_x1_A",     64'(sram_A),    64'd5);
    check("bp_x1_rdata", 64'(rsp_rdata), 64'hA000_0002);
    tick();
    req_vld = 1'b0;
    #1;
    check("bp_x2_rdata", 64'(rsp_rdata), 64'hA000_0003);
    tick();
    check("bp_x3_rdata", 64'(rsp_rdata), 64'hA000_0004);
    tick();
    check("bp_x4_vld",   64'(rsp_vld),   64'd1);
    check("bp_x4_rdata", 64'(rsp_rdata), 64'hA000_0005);
    tick();
    check("bp_x5_vld",   64'(rsp_vld),   64'd0);

    // 4. Streaming: 16 back-to-back reads with rsp_rdy held high.
    for (int i = 0; i < 16; i++) do_write(AW'(i), 32'hC0DE_0000 | DW'(i), 4'hF);
    req_vld = 1'b0;
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(j);
      end else begin
        req_vld = 1'b0;
      end
      #1;
      if (j < 16) check($sformatf("st_rdy_%0d", j), 64'(req_rdy), 64'd1);
      if (j >= 2) begin
        check($sformatf("st_vld_%0d", j),   64'(rsp_vld),   64'd1);
        check($sformatf("st_rdata_%0d", j), 64'(rsp_rdata), 64'(32'hC0DE_0000 | DW'(j - 2)));
      end else begin
        check($sformatf("st_vld_%0d", j), 64'(rsp_vld), 64'd0);
      end
      tick();
    end
    check("st_end_vld", 64'(rsp_vld), 64'd0);

    // 5a. Reset with three responses queued and one read pending.
    rsp_rdy = 1'b0;
    for (int a = 0; a < 4; a++) do_read(AW'(a));
    req_vld = 1'b0;
    RST_B = 1'b0;
    #1;
    check("mrst_pre_vld", 64'(rsp_vld), 64'd1);
    tick();
    check_reset_outputs("mrst1");
    RST_B = 1'b1;
    tick();
    check("mrst1_restart_A",   64'(sram_A),   64'd0);
    check("mrst1_restart_CEN", 64'(sram_CEN), 64'd0);
    check("mrst1_restart_vld", 64'(rsp_vld),  64'd0);

    // 5b. Reset at init_cnt=500.
    for (int i = 1; i <= 500; i++) tick();
    check("mrst2_pre_A", 64'(sram_A), 64'd500);
    RST_B = 1'b0;
    tick();
    check_reset_outputs("mrst2");
    RST_B = 1'b1;
    tick();
    check("mrst2_restart_A",   64'(sram_A),   64'd0);
    check("mrst2_restart_CEN", 64'(sram_CEN), 64'd0);
    for (int i = 1; i < 1024; i++) begin
      tick();
      check($sformatf("reinit_A_%0d", i),   64'(sram_A),  64'(i));
      check($sformatf("reinit_vld_%0d", i), 64'(rsp_vld), 64'd0);
    end
    tick();
    check("reinit_done",    64'(init_done), 64'd1);
    check("reinit_no_vld",  64'(rsp_vld),   64'd0);
    rsp_rdy = 1'b1;
    tick();
    check("reinit_no_stale", 64'(rsp_vld), 64'd0);
    // The re-init sweep cleared the earlier write to 0x15.
    do_read(10'h15);
    req_vld = 1'b0;
    #1;
    check("reinit_rd_n1_vld", 64'(rsp_vld), 64'd0);
    tick();
    check("reinit_rd_n2_vld",   64'(rsp_vld),   64'd1);
    check("reinit_rd_n2_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    check("reinit_rd_n3_vld", 64'(rsp_vld), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
